mem_access: RTL
===============

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk_i  in  1  pipeline clock; all state updates on posedge.
REQ-002 rst_i  in  1  reset; asynchronous, active-low.
REQ-003 MemRead_i, MemWrite_i  in  1 each  load/store request from EX/MEM register.
REQ-004 funct3_i  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
REQ-005 ALUres_i  in  32  byte address; also passed through on ALUres_o to MEMWB.
REQ-006 MemWdata_i  in  32  store data, right-aligned.
REQ-007 WB_i, WBSrc_i  in  1 each, rd_addr_i  in  5: writeback controls, passed through.
REQ-008 mem_req_o, mem_we_o  out  1 each; mem_addr_o  out  32 (word-aligned, [1:0]=00); mem_wdata_o  out  32; mem_wstrb_o  out  4: memory request port.
REQ-009 mem_ack_i  in  1, mem_rdata_i  in  32: memory response; mem_rdata_i is valid only in the ack cycle.
REQ-010 MemRdata_o  out  32, ALUres_o  out  32, rd_addr_o  out  5, WBSrc_o  out  1, WB_o  out  1: to MEMWB.
REQ-011 stall_o  out  1  freezes PC, IFID, IDEX and EXMEM while high.

Function
REQ-012 FSM states: IDLE, WAIT, DONE.
REQ-013 IDLE, no op: mem_req_o=0, stall_o=0, outputs pass through, MemRdata_o=0.
REQ-014 IDLE with MemRead_i|MemWrite_i: mem_req_o=1 and stall_o=1 in the same cycle; on mem_ack_i same cycle -> DONE, else -> WAIT.
REQ-015 WAIT: mem_req_o=1 with address, data, strobe and we held stable; stall_o=1; on mem_ack_i -> DONE; no timeout.
REQ-016 DONE: mem_req_o=0, stall_o=0, MemRdata_o driven from the data register captured at ack; next state IDLE unconditionally.
REQ-017 WB_o = WB_i & ~stall_o, so MEMWB receives a bubble during every stall cycle; rd_addr_o, WBSrc_o and ALUres_o are combinational pass-through.
REQ-018 Both MemRead_i and MemWrite_i high: treated as a store; the read is ignored.
REQ-019 Load extraction uses ALUres_i[1:0] as the lane: LB/LBU select a byte; LH/LHU select the half indicated by ALUres_i[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
REQ-020 Store strobes: SB 0001<<ALUres_i[1:0]; SH 0011 or 1100 by ALUres_i[1]; SW 1111. mem_wdata_o replicates the byte or half across all lanes.
REQ-021 mem_we_o=1 only for stores; for a store, MemRdata_o in DONE is 0.
REQ-022 Minimum access latency is 2 cycles: request/ack cycle, then DONE. Each additional ack-delay cycle adds one stall cycle.

Reset
REQ-023 rst_i low asynchronously forces state IDLE, the captured data register to 0, mem_req_o=0 and stall_o=0, including mid-WAIT; an abandoned request is not reissued.
REQ-024 After release, the first posedge with an op present starts a new access per REQ-014.

Configuration
REQ-025 MISALIGN_TRAP_EN defined: an LH/LHU/SH with ALUres_i[0]=1, or an LW/SW with ALUres_i[1:0]!=00, issues no request and causes no stall; WB_o is forced to 0 and misalign_o (out, 1) pulses high for one cycle.
REQ-026 MISALIGN_TRAP_EN undefined: misalign_o is absent; misaligned low address bits are ignored beyond the lane rules of REQ-019/020, and the access proceeds normally.

Verification
REQ-027 LW at 0x100, ack in the same cycle, rdata 0xDEADBEEF -> stall_o high for 1 cycle, MemRdata_o=0xDEADBEEF in DONE, WB_o=1 in DONE.
REQ-028 LB at 0x103, rdata 0x80FF0000, ack after 3 WAIT cycles -> stall_o high for 4 cycles, MemRdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-029 SH at 0x202, data 0x1234ABCD -> mem_addr_o=0x200, mem_wstrb_o=1100, mem_wdata_o=0xABCDABCD, mem_we_o=1, held stable until ack.
REQ-030 rst_i driven low during the 2nd WAIT cycle -> mem_req_o and stall_o go 0 immediately; after release, no request without a new op.
REQ-031 Back-to-back LW, LW, both acked immediately -> pattern stall 1,0,1,0; each DONE presents its own data.
REQ-032 With MISALIGN_TRAP_EN: LW at 0x101 -> no mem_req_o, misalign_o=1 for 1 cycle, WB_o=0, stall_o=0.

Source files
------------

// File: rtl/mem_access.sv
// Load/store unit of the MEM stage: sizes, aligns and issues one memory
// request per op, stalls until ack. Optional MISALIGN_TRAP_EN traps misalignment.
module mem_access (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] ALUres_i,
    input  logic [31:0] MemWdata_i,
    input  logic        WB_i,
    input  logic        WBSrc_i,
    input  logic [4:0]  rd_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] MemRdata_o,
    output logic [31:0] ALUres_o,
    output logic [4:0]  rd_addr_o,
    output logic        WBSrc_o,
    output logic        WB_o,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic        stall_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] data_q;
    logic [31:0] load_data;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic        op;
    logic        is_store;
    logic        is_load;
    logic        trap;
    logic        capture;
    logic        req;
    logic        stall;

    // A write wins over a simultaneous read
    assign op       = MemRead_i | MemWrite_i;
    assign is_store = MemWrite_i;
    assign is_load  = MemRead_i & ~MemWrite_i;

`ifdef MISALIGN_TRAP_EN
    logic mis;

    // Misalignment only matters for half and word accesses
    always_comb begin
        mis = 1'b0;
        unique case (funct3_i[1:0])
            2'b01:   mis = ALUres_i[0];
            2'b10:   mis = ALUres_i[1:0] != 2'b00;
            default: mis = 1'b0;
        endcase
    end

    assign trap       = op & mis;
    assign misalign_o = rst_i & (state == IDLE) & trap;
`else
    assign trap = 1'b0;
`endif

    // Pick the addressed byte and half out of the returned word
    always_comb begin
        lane_byte = 8'h00;
        unique case (ALUres_i[1:0])
            2'b00: lane_byte = mem_rdata_i[7:0];
            2'b01: lane_byte = mem_rdata_i[15:8];
            2'b10: lane_byte = mem_rdata_i[23:16];
            2'b11: lane_byte = mem_rdata_i[31:24];
        endcase
        lane_half = ALUres_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    end

    // Sign- or zero-extend according to funct3[2]
    always_comb begin
        load_data = mem_rdata_i;
        unique case (funct3_i[1:0])
            2'b00:
                load_data = {{24{~funct3_i[2] & lane_byte[7]}}, lane_byte};
            2'b01:
                load_data = {{16{~funct3_i[2] & lane_half[15]}}, lane_half};
            default:
                load_data = mem_rdata_i;
        endcase
    end

    // Store strobes and lane-replicated write data
    always_comb begin
        mem_wstrb_o = 4'b0000;
        mem_wdata_o = MemWdata_i;
        unique case (funct3_i[1:0])
            2'b00: begin
                mem_wstrb_o = 4'b0001 << ALUres_i[1:0];
                mem_wdata_o = {4{MemWdata_i[7:0]}};
            end
            2'b01: begin
                mem_wstrb_o = ALUres_i[1] ? 4'b1100 : 4'b0011;
                mem_wdata_o = {2{MemWdata_i[15:0]}};
            end
            default: begin
                mem_wstrb_o = 4'b1111;
                mem_wdata_o = MemWdata_i;
            end
        endcase
        if (!is_store) mem_wstrb_o = 4'b0000;
    end

    // Next state, request, stall and read-data mux
    always_comb begin
        state_nx   = state;
        req        = 1'b0;
        stall      = 1'b0;
        capture    = 1'b0;
        MemRdata_o = 32'h0;
        unique case (state)
            IDLE: begin
                if (op && !trap) begin
                    req      = 1'b1;
                    stall    = 1'b1;
                    capture  = mem_ack_i;
                    state_nx = mem_ack_i ? DONE : WAIT;
                end
            end
            WAIT: begin
                req   = 1'b1;
                stall = 1'b1;
                if (mem_ack_i) begin
                    capture  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                MemRdata_o = data_q;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_req_o  = req & rst_i;
    assign stall_o    = stall & rst_i;
    assign mem_we_o   = mem_req_o & is_store;
    assign mem_addr_o = {ALUres_i[31:2], 2'b00};
    assign WB_o       = WB_i & ~stall_o & ~trap;
    assign ALUres_o   = ALUres_i;
    assign rd_addr_o  = rd_addr_i;
    assign WBSrc_o    = WBSrc_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    // Load result captured in the ack cycle; stores return zero
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)       data_q <= 32'h0;
        else if (capture) data_q <= is_load ? load_data : 32'h0;
    end

endmodule
